// File: rtl/pr_decoder_grant.sv
// 3:8 grant decoder: latches an encoder code and drives a registered one-hot grant for HOLD cycles, then idles GAP cycles.
// Latency: grant appears one edge after acceptance; backpressure via ready (high only in IDLE, no input-to-ready path).
module pr_decoder_grant #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_in,
    input  logic       idle_in,
    input  logic       ack_in,
    output logic       ready,
    output logic [7:0] grant,
    output logic [2:0] grant_code,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] code_q,  code_d;
    logic       done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            grant_q <= 8'h00;
            code_q  <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    // One shared down-counter times both the grant hold and the recovery gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        code_d  = code_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                grant_d = 8'h00;
                if (!idle_in) begin
                    code_d  = code_in;
                    grant_d = 8'h01 << code_in;
                    cnt_d   = HOLD_M1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ack_in || (cnt_q == 8'd0)) begin
                    grant_d = 8'h00;
                    done_d  = 1'b1;
                    if (GAP > 0) begin
                        cnt_d   = GAP_M1;
                        state_d = S_RECOVER;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RECOVER: begin
                grant_d = 8'h00;
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                grant_d = 8'h00;
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready      = (state_q == S_IDLE);
    assign grant      = grant_q;
    assign grant_code = code_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pr_decoder_grant.sv
// Directed bench for pr_decoder_grant (HOLD=4, GAP=1); outputs sampled on the falling clock edge.
module tb_pr_decoder_grant;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] code_in;
    logic       idle_in;
    logic       ack_in;
    logic       ready;
    logic [7:0] grant;
    logic [2:0] grant_code;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    pr_decoder_grant #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .idle_in    (idle_in),
        .ack_in     (ack_in),
        .ready      (ready),
        .grant      (grant),
        .grant_code (grant_code),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with ready=1. Presents code c; ack_k>0 raises ack_in for the
    // edge E0+ack_k; chain keeps idle_in low and switches code_in to next_c after acceptance.
    task automatic run_grant(input logic [2:0] c, input int ack_k, input bit chain, input logic [2:0] next_c);
        int len;
        len = (ack_k > 0 && ack_k < HOLD) ? ack_k : HOLD;
        chk("ready_before", {7'd0, ready}, 8'h01);
        code_in = c;
        idle_in = 1'b0;
        ack_in  = 1'b0;
        for (int i = 1; i <= len + GAP + 1; i++) begin
            @(negedge clk);
            chk("grant",      grant, (i <= len) ? (8'h01 << c) : 8'h00);
            chk("onehot",     {7'd0, $onehot0(grant)}, 8'h01);
            chk("done",       {7'd0, done},  (i == len + 1) ? 8'h01 : 8'h00);
            chk("ready",      {7'd0, ready}, (i > len + GAP) ? 8'h01 : 8'h00);
            chk("grant_code", {5'd0, grant_code}, {5'd0, c});
            if (i == 1) begin
                if (chain) code_in = next_c;
                else       idle_in = 1'b1;
            end
            if (ack_k > 0 && i == ack_k)     ack_in = 1'b1;
            if (ack_k > 0 && i == ack_k + 1) ack_in = 1'b0;
        end
        ack_in = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        code_in = 3'd0;
        idle_in = 1'b1;
        ack_in  = 1'b0;
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_ready", {7'd0, ready}, 8'h01);
        chk("rst_done",  {7'd0, done},  8'h00);
        chk("rst_code",  {5'd0, grant_code}, 8'h00);

        // Reset for 3 cycles, then 10 idle cycles
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_grant", grant, 8'h00);
            chk("idle_ready", {7'd0, ready}, 8'h01);
            chk("idle_done",  {7'd0, done},  8'h00);
        end

        // Single grant of code 5
        run_grant(3'd5, 0, 1'b0, 3'd0);

        // Full sweep of all codes
        for (int c = 0; c < 8; c++) begin
            run_grant(3'(c), 0, 1'b0, 3'd0);
        end

        // Early ack on the first edge after acceptance
        run_grant(3'd2, 1, 1'b0, 3'd0);
        // Ack mid-grant, and ack coinciding with the final hold cycle
        run_grant(3'd6, 2, 1'b0, 3'd0);
        run_grant(3'd4, HOLD, 1'b0, 3'd0);

        // Input change mid-grant followed by a back-to-back accept of code 7
        run_grant(3'd1, 0, 1'b1, 3'd7);
        run_grant(3'd7, 0, 1'b0, 3'd0);

        // Asynchronous reset between edges during cycle 2 of a code-3 grant
        code_in = 3'd3;
        idle_in = 1'b0;
        @(negedge clk);
        idle_in = 1'b1;
        chk("ar_grant_pre", grant, 8'h08);
        @(posedge clk);
        #2;
        chk("ar_grant_mid", grant, 8'h08);
        rst_n = 1'b0;
        #1;
        chk("ar_grant",  grant, 8'h00);
        chk("ar_done",   {7'd0, done},  8'h00);
        chk("ar_ready",  {7'd0, ready}, 8'h01);
        chk("ar_code",   {5'd0, grant_code}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ar_post_grant", grant, 8'h00);
            chk("ar_post_done",  {7'd0, done},  8'h00);
            chk("ar_post_ready", {7'd0, ready}, 8'h01);
        end

        // Normal operation resumes after reset
        run_grant(3'd0, 0, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
